// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes from ALU control and the
// execute-stage FSM state encoding.
package alu_pkg;

  localparam int unsigned CTL_W = 4;

  localparam logic [CTL_W-1:0] ALU_AND = 4'd0;
  localparam logic [CTL_W-1:0] ALU_OR  = 4'd1;
  localparam logic [CTL_W-1:0] ALU_ADD = 4'd2;
  localparam logic [CTL_W-1:0] ALU_MUL = 4'd3;
  localparam logic [CTL_W-1:0] ALU_SUB = 4'd6;
  localparam logic [CTL_W-1:0] ALU_SLT = 4'd7;
  localparam logic [CTL_W-1:0] ALU_NOR = 4'd12;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Valid/ready operand and result bus between ALU control, the execute
// stage and the writeback/branch consumer.
interface alu_exec_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_ctl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_err;

  modport master (
    output in_valid, alu_ctl, op_a, op_b, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_err
  );

  modport slave (
    input  in_valid, alu_ctl, op_a, op_b, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_err
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Radix-2 shift-add unsigned multiplier, one multiplier bit per cycle.
// The start edge consumes bit 0, so done pulses WIDTH-1 cycles later.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      a_sh_q <= '0;
      b_sh_q <= '0;
      cnt_q  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc_q  <= {WIDTH{b[0]}} & a;
        a_sh_q <= a << 1;
        b_sh_q <= b >> 1;
        cnt_q  <= CNT_W'(WIDTH - 1);
        busy   <= 1'b1;
      end else if (busy) begin
        if (b_sh_q[0]) begin
          acc_q <= acc_q + a_sh_q;
        end
        a_sh_q <= a_sh_q << 1;
        b_sh_q <= b_sh_q >> 1;
        cnt_q  <= cnt_q - CNT_W'(1);
        // last partial product lands this edge
        if (cnt_q == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign product = acc_q;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle ALU ops into a handshaked result register.
// Define ALU_MUL_EN to add the iterative multiplier on code 3 (latency WIDTH).
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  alu_exec_unit_if.slave bus
);
  logic             accept;
  logic             in_ready_c;
  logic             load;
  logic [WIDTH-1:0] alu_res;
  logic             alu_err;
  logic [WIDTH-1:0] next_res;
  logic             next_err;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_result_q;
  logic             out_zero_q;
  logic             out_err_q;

  assign accept = bus.in_valid && in_ready_c;

  // Single-cycle datapath; unsupported codes yield a zero result with err.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (bus.alu_ctl)
      ALU_AND: alu_res = bus.op_a & bus.op_b;
      ALU_OR:  alu_res = bus.op_a | bus.op_b;
      ALU_ADD: alu_res = bus.op_a + bus.op_b;
      ALU_SUB: alu_res = bus.op_a - bus.op_b;
      ALU_SLT: alu_res = WIDTH'($signed(bus.op_a) < $signed(bus.op_b));
      ALU_NOR: alu_res = ~(bus.op_a | bus.op_b);
`ifdef ALU_MUL_EN
      ALU_MUL: alu_res = '0;
`endif
      default: alu_err = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  state_t           state_q;
  state_t           state_d;
  logic             is_mul;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  assign is_mul = (bus.alu_ctl == ALU_MUL);

  alu_mul_seq #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (mul_start),
    .a      (bus.op_a),
    .b      (bus.op_b),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(mul_product)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && is_mul) begin
          state_d   = MUL;
          mul_start = 1'b1;
        end
      end
      MUL: begin
        if (mul_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready_c = (state_q == IDLE) && !mul_busy && (!out_valid_q || bus.out_ready);
  assign load       = (accept && !is_mul) || mul_done;
  assign next_res   = mul_done ? mul_product : alu_res;
  assign next_err   = mul_done ? 1'b0 : alu_err;
`else
  assign in_ready_c = !out_valid_q || bus.out_ready;
  assign load       = accept;
  assign next_res   = alu_res;
  assign next_err   = alu_err;
`endif

  // Result register: holds under backpressure, reloads on same-edge accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_zero_q   <= 1'b0;
      out_err_q    <= 1'b0;
    end else if (load) begin
      out_valid_q  <= 1'b1;
      out_result_q <= next_res;
      out_zero_q   <= (next_res == '0);
      out_err_q    <= next_err;
    end else if (bus.out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_zero   = out_zero_q;
  assign bus.out_err    = out_err_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed ops push expected results,
// a negedge monitor pops and compares whenever out_valid is presented.
module tb_alu_exec_unit;
  localparam int unsigned W = 32;

  logic clk;
  logic reset;
  int   cyc;
  int   n_chk;
  int   n_pass;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         err;
    int           due;
  } exp_t;

  exp_t sb[$];
  logic seen;

  alu_exec_unit_if #(.WIDTH(W)) bus ();

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: compare the presented result against the scoreboard head.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      seen = 1'b0;
    end else if (bus.out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 64'(bus.out_valid), 64'(0));
      end else begin
        if (!seen) begin
          chk("latency", 64'(cyc), 64'(sb[0].due));
          seen = 1'b1;
        end
        chk("out_result", 64'(bus.out_result), 64'(sb[0].res));
        chk("out_zero", 64'(bus.out_zero), 64'(sb[0].zero));
        chk("out_err", 64'(bus.out_err), 64'(sb[0].err));
        if (bus.out_ready) begin
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  // Present an op, wait for acceptance, record the expected response.
  task automatic issue(input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic ez, input logic ee,
                       input int extra, output int waits);
    bus.in_valid = 1'b1;
    bus.alu_ctl  = ctl;
    bus.op_a     = a;
    bus.op_b     = b;
    waits = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      waits++;
      if (waits > 200) break;
    end
    if (waits > 200) begin
      chk("accept_timeout", 64'(bus.in_ready), 64'(1));
    end else begin
      sb.push_back('{er, ez, ee, cyc + 1 + extra});
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    n_chk  = 0;
    n_pass = 0;
    seen   = 1'b0;
    reset  = 1'b1;
    bus.in_valid  = 1'b0;
    bus.alu_ctl   = 4'd0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.out_ready = 1'b1;

    idle(2);
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_result", 64'(bus.out_result), 64'(0));
    chk("rst_out_zero", 64'(bus.out_zero), 64'(0));
    chk("rst_out_err", 64'(bus.out_err), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    reset = 1'b0;
    idle(1);

    issue(4'd2, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 0, w);
    chk("add_wait", 64'(w), 64'(0));

    issue(4'd6, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0, 0, w);
    issue(4'd7, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 0, w);
    chk("b2b_wait", 64'(w), 64'(0));

    issue(4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 0, w);
    issue(4'd12, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, w);
    issue(4'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 0, w);
    issue(4'd6, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 0, w);
    issue(4'd7, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 0, w);
    issue(4'd7, 32'h8000_0000, 32'd0, 32'd1, 1'b0, 1'b0, 0, w);

    issue(4'd15, 32'd9, 32'd9, 32'd0, 1'b1, 1'b1, 0, w);
    issue(4'd4, 32'd1, 32'd2, 32'd0, 1'b1, 1'b1, 0, w);
`ifndef ALU_MUL_EN
    issue(4'd3, 32'd6, 32'd7, 32'd0, 1'b1, 1'b1, 0, w);
`endif
    chk("illegal_wait", 64'(w), 64'(0));
    idle(2);

    // Backpressure: result held for 4 cycles while the next op waits.
    bus.out_ready = 1'b0;
    issue(4'd1, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0, 0, w);
    bus.in_valid = 1'b1;
    bus.alu_ctl  = 4'd2;
    bus.op_a     = 32'd1;
    bus.op_b     = 32'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
      chk("bp_hold", 64'(bus.out_result), 64'h0000_00FF);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    issue(4'd2, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 0, w);
    chk("bp_release_wait", 64'(w), 64'(0));
    idle(2);

    // Reset while an error result is held under backpressure.
    bus.out_ready = 1'b0;
    issue(4'd9, 32'd1, 32'd1, 32'd0, 1'b1, 1'b1, 0, w);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_hold_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_hold_result", 64'(bus.out_result), 64'(0));
    chk("rst_hold_zero", 64'(bus.out_zero), 64'(0));
    chk("rst_hold_err", 64'(bus.out_err), 64'(0));
    @(negedge clk);
    #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    idle(1);
    issue(4'd2, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 0, w);
    idle(2);

`ifdef ALU_MUL_EN
    issue(4'd3, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0, int'(W), w);
    @(negedge clk);
    chk("mul_in_ready", 64'(bus.in_ready), 64'(0));
    issue(4'd3, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, 1'b0, int'(W), w);
    chk("mul_stall", 64'(w > 20), 64'(1));
    idle(W + 4);

    // Reset in cycle 10 of a multiply: op lost, stage idle again.
    issue(4'd3, 32'd5, 32'd5, 32'd25, 1'b0, 1'b0, int'(W), w);
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mulrst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("mulrst_in_ready", 64'(bus.in_ready), 64'(1));
    @(negedge clk);
    #1;
    reset = 1'b0;
    idle(1);
    issue(4'd2, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 0, w);
    chk("mulrst_add_wait", 64'(w), 64'(0));
    idle(W + 8);
`endif

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
